// File: rtl/counter_share_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : counter_share_arbiter_pkg
// Purpose  : Shared definitions for the counter-sharing arbiter: FSM state
//            encodings, default width constants and a small index helper.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_share_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 3;
  localparam int DEF_LEN_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // (a + b) mod n, used to walk the round-robin search order.
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_ld_sync.sv
//------------------------------------------------------------------------------
// Module   : counter_ld_sync
// Purpose  : CNT_W-bit loadable up-counter with synchronous active-low reset.
//            Load has priority over enable; counting wraps modulo 2**CNT_W.
// Ports    : clk          rising-edge clock
//            reset_al_in  synchronous active-low reset (count -> 0)
//            load_in      load d_in on the next edge
//            en_in        increment on the next edge
//            d_in         load value
//            count_out    current count (registered)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_ld_sync #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic             load_in,
  input  logic             en_in,
  input  logic [CNT_W-1:0] d_in,
  output logic [CNT_W-1:0] count_out
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_al_in) begin
      r_count <= '0;
    end else if (load_in) begin
      r_count <= d_in;
    end else if (en_in) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count_out = r_count;

endmodule

`default_nettype wire

// File: rtl/counter_share_arbiter.sv
//------------------------------------------------------------------------------
// Module   : counter_share_arbiter
// Purpose  : Shares one loadable up-counter between NUM_REQ requesters.
//            A round-robin pick selects a requester in IDLE, its start/len are
//            latched, the counter is loaded (LOAD), counts len+1 values (RUN)
//            and the owner receives a one-cycle done pulse (DONE).
// Ports    : clk              rising-edge clock
//            reset_al_in      synchronous active-low reset
//            req_in           level request per requester
//            start_flat_in    start values, requester i at [i*CNT_W +: CNT_W]
//            len_flat_in      lengths, requester i at [i*LEN_W +: LEN_W]
//            grant_out        one-hot grant, held for the whole session
//            busy_out         high in LOAD, RUN and DONE
//            count_out        shared counter value (held outside RUN)
//            count_valid_out  count_out is a session count (RUN only)
//            done_out         one-cycle pulse to the owner at session end
// Config   : COUNTER_SHARE_ABORT_EN - when defined, the owner dropping its
//            request during LOAD or RUN ends the session without done.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_share_arbiter
  import counter_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                     clk,
  input  logic                     reset_al_in,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*CNT_W-1:0] start_flat_in,
  input  logic [NUM_REQ*LEN_W-1:0] len_flat_in,
  output logic [NUM_REQ-1:0]       grant_out,
  output logic                     busy_out,
  output logic [CNT_W-1:0]         count_out,
  output logic                     count_valid_out,
  output logic [NUM_REQ-1:0]       done_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_busy;
  logic               r_valid;
  logic [CNT_W-1:0]   r_start;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_rem;

  logic [CNT_W-1:0]   w_start_arr [NUM_REQ];
  logic [LEN_W-1:0]   w_len_arr   [NUM_REQ];
  logic               w_found;
  logic [PTR_W-1:0]   w_pick;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_abort;
  logic               w_load;
  logic               w_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_start_arr[gi] = start_flat_in[gi*CNT_W +: CNT_W];
      assign w_len_arr[gi]   = len_flat_in[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Round-robin pick: first set request searching rr_ptr, rr_ptr+1, ...
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'(wrap_add(int'(r_rr_ptr), k, NUM_REQ));
      if (!w_found && req_in[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_next_ptr = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

`ifdef COUNTER_SHARE_ABORT_EN
  logic w_owner_req;
  // r_grant is one-hot on the owner, so this isolates the owner's request.
  assign w_owner_req = |(req_in & r_grant);
  assign w_abort     = ((r_state == ST_LOAD) || (r_state == ST_RUN)) && !w_owner_req;
`else
  assign w_abort     = 1'b0;
`endif

  // The counter does not advance on the final RUN edge, so it holds start+len
  // after the session instead of running one past it.
  assign w_load = (r_state == ST_LOAD) && !w_abort;
  assign w_en   = (r_state == ST_RUN) && (r_rem != '0) && !w_abort;

  always_ff @(posedge clk) begin
    if (!reset_al_in) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_start  <= '0;
      r_len    <= '0;
      r_rem    <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_LOAD;
            r_owner <= w_pick;
            r_grant <= NUM_REQ'(1) << w_pick;
            r_start <= w_start_arr[w_pick];
            r_len   <= w_len_arr[w_pick];
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_abort) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end else begin
            r_rem   <= r_len;
            r_valid <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end else if (r_rem == '0) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_done  <= r_grant;
          end else begin
            r_rem <= r_rem - LEN_W'(1);
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_grant  <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_next_ptr;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  counter_ld_sync #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk         (clk),
    .reset_al_in (reset_al_in),
    .load_in     (w_load),
    .en_in       (w_en),
    .d_in        (r_start),
    .count_out   (count_out)
  );

  assign grant_out       = r_grant;
  assign done_out        = r_done;
  assign busy_out        = r_busy;
  assign count_valid_out = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_counter_share_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_counter_share_arbiter
// Purpose  : Self-checking bench for counter_share_arbiter. A session-timeline
//            model predicts every output each cycle; directed scenarios pin
//            literal count/grant/done sequences; a random phase follows.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter_share_arbiter;

  localparam int N  = 4;
  localparam int CW = 3;
  localparam int LW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*CW-1:0] start_flat;
  logic [N*LW-1:0] len_flat;
  logic [N-1:0]    grant_out;
  logic            busy_out;
  logic [CW-1:0]   count_out;
  logic            count_valid_out;
  logic [N-1:0]    done_out;

  always #5 clk = ~clk;

  counter_share_arbiter #(
    .NUM_REQ (N),
    .CNT_W   (CW),
    .LEN_W   (LW)
  ) dut (
    .clk             (clk),
    .reset_al_in     (rst_n),
    .req_in          (req),
    .start_flat_in   (start_flat),
    .len_flat_in     (len_flat),
    .grant_out       (grant_out),
    .busy_out        (busy_out),
    .count_out       (count_out),
    .count_valid_out (count_valid_out),
    .done_out        (done_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Session timeline model: a session accepted at edge N occupies relative
  // cycles t=1..len+3 (t=1 grant only, t=2..len+2 valid counts, t=len+3 done).
  bit m_init   = 0;
  bit m_active = 0;
  int m_t, m_owner, m_start, m_len;
  int m_ptr    = 0;
  int m_count  = 0;

  always @(posedge clk) begin
    bit found;
    bit stop;
    if (rst_n !== 1'b1) begin
      m_init   = 1;
      m_active = 0;
      m_ptr    = 0;
      m_count  = 0;
    end else if (!m_active) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found   = 1;
          m_owner = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_active = 1;
        m_t      = 1;
        m_start  = int'(start_flat[m_owner*CW +: CW]);
        m_len    = int'(len_flat[m_owner*LW +: LW]);
      end
    end else begin
      stop = (m_t == m_len + 3);
`ifdef COUNTER_SHARE_ABORT_EN
      if (m_t <= m_len + 2 && !req[m_owner]) stop = 1;
`endif
      if (stop) begin
        m_active = 0;
        m_ptr    = (m_owner + 1) % N;
      end else begin
        m_t++;
      end
    end
    if (m_active && m_t >= 2 && m_t <= m_len + 2)
      m_count = (m_start + m_t - 2) % (1 << CW);
  end

  int         q_cnt[$];
  int         q_gnt[$];
  int         q_done[$];
  logic [N-1:0] g_prev = '0;

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    int eg, ed;
    bit ev;
    if (m_init) begin
      ev = m_active && m_t >= 2 && m_t <= m_len + 2;
      eg = m_active ? (1 << m_owner) : 0;
      ed = (m_active && m_t == m_len + 3) ? (1 << m_owner) : 0;
      check("grant", int'(grant_out), eg);
      check("busy", int'(busy_out), int'(m_active));
      check("valid", int'(count_valid_out), int'(ev));
      check("count", int'(count_out), m_count);
      check("done", int'(done_out), ed);
      if (count_valid_out === 1'b1) q_cnt.push_back(int'(count_out));
      if (grant_out != '0 && g_prev == '0) q_gnt.push_back(oh_idx(grant_out));
      if (done_out != '0) q_done.push_back(int'(done_out));
      g_prev = grant_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sess(input int i, input int s, input int l);
    start_flat[i*CW +: CW] = CW'(s);
    len_flat[i*LW +: LW]   = LW'(l);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick(2);
    rst_n = 1'b1;
    q_cnt.delete();
    q_gnt.delete();
    q_done.delete();
  endtask

  // Wait (bounded) until the given grant pattern is visible.
  task automatic wait_grant(input string name, input logic [N-1:0] g);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(1);
      if (grant_out == g) seen = 1;
    end
    check(name, int'(seen), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    int e3[4];
    rst_n      = 1'b0;
    req        = '0;
    start_flat = '0;
    len_flat   = '0;
    tick(3);

    // T1: reset in the 2nd RUN cycle kills the session
    do_reset();
    set_sess(0, 5, 2);
    req  = 4'b0001;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      if (count_valid_out) seen = 1;
    end
    check("T1 reach RUN", int'(seen), 1);
    check("T1 first count", int'(count_out), 5);
    tick(1);
    rst_n = 1'b0;
    req   = '0;
    tick(1);
    check("T1 grant", int'(grant_out), 0);
    check("T1 busy", int'(busy_out), 0);
    check("T1 valid", int'(count_valid_out), 0);
    check("T1 count", int'(count_out), 0);
    check("T1 done", int'(done_out), 0);
    rst_n = 1'b1;
    tick(6);
    check("T1 no done pulse", q_done.size(), 0);

    // T2: single session
    do_reset();
    set_sess(0, 2, 3);
    req = 4'b0001;
    tick(1);
    check("T2 grant", int'(grant_out), 1);
    req = '0;
    tick(10);
    check("T2 ncounts", q_cnt.size(), 4);
    for (int i = 0; i < 4; i++) check("T2 count", q_cnt[i], 2 + i);
    check("T2 ndone", q_done.size(), 1);
    check("T2 done", q_done[0], 1);

    // T3: wrap
    do_reset();
    set_sess(0, 6, 3);
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(10);
    e3 = '{6, 7, 0, 1};
    check("T3 ncounts", q_cnt.size(), 4);
    for (int i = 0; i < 4; i++) check("T3 count", q_cnt[i], e3[i]);

    // T4: round-robin with all four requesting, len=0
    do_reset();
    for (int i = 0; i < N; i++) set_sess(i, i, 0);
    req = 4'b1111;
    tick(26);
    req = '0;
    tick(6);
    check("T4 ngrants", int'(q_gnt.size() >= 5), 1);
    for (int i = 0; i < 5; i++) check("T4 grant order", q_gnt[i], i % 4);
    for (int i = 0; i < 5; i++) check("T4 one count", q_cnt[i], i % 4);

    // T5: fairness between req0 and req2
    do_reset();
    for (int i = 0; i < N; i++) set_sess(i, 1, 1);
    req = 4'b0101;
    tick(30);
    req = '0;
    tick(6);
    check("T5 grant0", q_gnt[0], 0);
    check("T5 grant1", q_gnt[1], 2);
    check("T5 grant2", q_gnt[2], 0);
    for (int i = 1; i < q_gnt.size(); i++)
      check("T5 no repeat", int'(q_gnt[i] == q_gnt[i-1]), 0);

    // T6: owner drops its request in the 1st RUN cycle
    do_reset();
    set_sess(1, 0, 5);
    set_sess(2, 3, 1);
    req  = 4'b0010;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      if (count_valid_out) seen = 1;
    end
    check("T6 reach RUN", int'(seen), 1);
    req = 4'b0100;
    tick(1);
`ifdef COUNTER_SHARE_ABORT_EN
    check("T6 abort busy", int'(busy_out), 0);
    check("T6 abort done", int'(done_out), 0);
`else
    check("T6 still busy", int'(busy_out), 1);
`endif
    wait_grant("T6 grant2", 4'b0100);
    req = '0;
    tick(8);
    check("T6 grant seq0", q_gnt[0], 1);
    check("T6 grant seq1", q_gnt[1], 2);
`ifdef COUNTER_SHARE_ABORT_EN
    check("T6 ndone", q_done.size(), 1);
    check("T6 done", q_done[0], 4);
    check("T6 ncounts", q_cnt.size(), 3);
    check("T6 count0", q_cnt[0], 0);
    check("T6 count1", q_cnt[1], 3);
`else
    check("T6 ndone", q_done.size(), 2);
    check("T6 done1", q_done[0], 2);
    check("T6 done2", q_done[1], 4);
    check("T6 ncounts", q_cnt.size(), 8);
    for (int i = 0; i < 6; i++) check("T6 count", q_cnt[i], i);
`endif

    // Random phase: requests held for random spans, occasional reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = N'($urandom_range(0, (1 << N) - 1));
        for (int i = 0; i < N; i++)
          set_sess(i, $urandom_range(0, 7), $urandom_range(0, 7));
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    req   = '0;
    tick(15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
